el2_dec_trigger_ctl: RTL and testbench
======================================

Name: el2_dec_trigger_ctl

Overview:
Owns the four debug-trigger CSR sets (mtsel, mtdata1, mtdata2) and builds the trigger packets used by the decode and LSU mask-and-match datapaths.
Collects their raw per-trigger matches, applies chaining and privilege qualification, and latches a hit that is held until the TLU takes it.
Sits in DEC beside the TLU CSR file and presents one hit/ack handshake to the TLU.

Parameters:
NTRIG, 4, number of triggers; fixed at 4 because chaining pairs 0-1 and 2-3.

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
csr_wr_en  in  1  CSR write strobe
csr_wr_addr  in  2  0=mtsel, 1=mtdata1, 2=mtdata2, 3=ignored
csr_wr_data  in  32  write data
csr_rd_addr  in  2  read select
csr_rd_data  out  32  combinational read of the addressed register (trigger indexed by mtsel)
dbg_mode  in  1  core is in debug mode
i0_valid  in  1  decode instruction valid
i0_match  in  4  raw execute-address match per trigger
lsu_valid  in  1  LSU access valid
lsu_match  in  4  raw load/store match per trigger
trigger_pkt_any  out  4 x el2_trigger_pkt_t  select, match, store, load, execute, m, tdata2 per trigger
trig_hit_valid  out  1  latched hit pending
trig_hit_vec  out  4  triggers that fired
trig_action  out  1  0=breakpoint exception, 1=enter debug mode
trig_hit_ack  in  1  TLU consumed the hit

Behaviour:
- Reset values:
  - mtsel=0; all mtdata1/mtdata2 fields=0; state IDLE.
  - trig_hit_valid=0, trig_hit_vec=0, trig_action=0.
  - trigger_pkt_any all zero; csr_rd_data follows the zeroed registers.
- mtdata1 layout:
  - [31:28] type, read as 2, not writable.
  - [27] dmode, [20] hit, [19] select, [12] action, [11] chain, [7] match, [6] m, [2] execute, [1] store, [0] load.
  - All other bits read 0.
- mtsel stores bits [1:0] only; writing 5 gives 1 (wrap).
- Write protection: if the selected trigger has dmode=1 and dbg_mode=0, writes to its mtdata1/mtdata2 are dropped. dmode itself is writable only when dbg_mode=1.
- chain is writable only on triggers 0 and 2; reads 0 on triggers 1 and 3.
- CSR writes take effect the next cycle. trigger_pkt_any is a combinational map of the current registers.
- Qualified raw hit per trigger i: q[i] = m & ~dbg_mode & ((execute & i0_valid & i0_match[i]) | ((load|store) & lsu_valid & lsu_match[i])).
- Chaining: if chain[2k]=1, both members of pair k require q[2k] & q[2k+1], and both fire together. Otherwise each member fires on its own q.
- FSM IDLE:
  - Any fired trigger moves the FSM to PEND on the next edge.
  - On that edge: latch trig_hit_vec; trig_action = OR of action over the fired triggers; set hit=1 in each fired mtdata1.
- FSM PEND:
  - trig_hit_valid=1; latched outputs stay stable.
  - New matches are ignored: no hit-bit update, no vector change.
  - trig_hit_ack moves the FSM to IDLE on the next edge, with vec/action cleared.
  - A match in the ack cycle is dropped.
- trig_hit_ack while IDLE is ignored.
- Latency: match in cycle N gives trig_hit_valid=1 in cycle N+1.
- Same-cycle CSR write to a trigger's mtdata1 and a hit-bit set on that trigger: the write wins.
- rst_l assertion mid-PEND returns everything to reset values immediately (asynchronous).

Decomposition:
- el2_pkg holds:
  - el2_trigger_pkt_t;
  - localparams for the CSR sub-addresses and mtdata1 bit positions;
  - an FSM enum {IDLE, PEND}.
- Sub-module el2_trig_chain: purely combinational. Takes q[3:0], chain[0], chain[2] and produces fired[3:0].
- CSR storage and the FSM stay in the top block.

Test Plan:
1. CSR map: write mtsel=2, mtdata1=0x0000_0044, mtdata2=0x8000_0100.
   - Read back mtdata1 = 0x2000_0044.
   - trigger_pkt_any[2] shows execute=1, m=1, tdata2=0x8000_0100.
2. Single execute hit: trigger 1 execute=1, m=1; drive i0_valid=1, i0_match=4'b0010.
   - Next cycle: trig_hit_valid=1, trig_hit_vec=4'b0010, trig_action=0, mtdata1[1].hit=1.
   - Ack returns trig_hit_valid to 0 the following cycle.
3. Chaining: chain[0]=1, triggers 0 and 1 armed.
   - i0_match=4'b0001 gives no hit.
   - i0_match=4'b0011 gives trig_hit_vec=4'b0011.
4. Dmode protection: trigger 3 dmode=1 written in dbg_mode.
   - With dbg_mode=0, a write of mtdata2=0xFFFF_FFFF is ignored; the old value reads back.
   - Matches are suppressed while dbg_mode=1.
5. Pending behaviour: hold in PEND, drive lsu_valid=1 with lsu_match=4'b1000 on trigger 3 (load=1).
   - trig_hit_vec stays at its first value; trigger 3 hit bit stays 0.
   - A same-cycle mtdata1 write and hit-set on one trigger leaves the written value.
6. Reset mid-PEND: drop rst_l asynchronously.
   - trig_hit_valid=0 and mtsel=0 without waiting for a clock edge.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared types and constants for the debug-trigger control block.
// Holds the trigger packet layout, CSR sub-addresses and mtdata1 bit positions.
package el2_pkg;

  localparam int NTRIG = 4;

  localparam logic [1:0] CSR_MTSEL   = 2'd0;
  localparam logic [1:0] CSR_MTDATA1 = 2'd1;
  localparam logic [1:0] CSR_MTDATA2 = 2'd2;

  localparam logic [3:0] MTDATA1_TYPE = 4'd2;

  localparam int B_DMODE  = 27;
  localparam int B_HIT    = 20;
  localparam int B_SELECT = 19;
  localparam int B_ACTION = 12;
  localparam int B_CHAIN  = 11;
  localparam int B_MATCH  = 7;
  localparam int B_M      = 6;
  localparam int B_EXEC   = 2;
  localparam int B_STORE  = 1;
  localparam int B_LOAD   = 0;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } el2_trigger_pkt_t;

  typedef enum logic {IDLE, PEND} trig_state_e;

endpackage

// File: rtl/el2_trig_chain.sv
// Combinational chaining of qualified trigger hits; pairs are 0-1 and 2-3.
// With a pair chained, both members need both qualified hits and fire together.
module el2_trig_chain
  import el2_pkg::*;
(
  input  logic [NTRIG-1:0] i_q,
  input  logic             i_chain0,
  input  logic             i_chain2,
  output logic [NTRIG-1:0] o_fired
);

  logic w_pair0;
  logic w_pair1;

  assign w_pair0 = i_q[0] & i_q[1];
  assign w_pair1 = i_q[2] & i_q[3];

  assign o_fired[0] = i_chain0 ? w_pair0 : i_q[0];
  assign o_fired[1] = i_chain0 ? w_pair0 : i_q[1];
  assign o_fired[2] = i_chain2 ? w_pair1 : i_q[2];
  assign o_fired[3] = i_chain2 ? w_pair1 : i_q[3];

endmodule

// File: rtl/el2_dec_trigger_ctl.sv
// Debug-trigger CSRs, trigger packet generation and hit latching toward the TLU.
// A fired trigger raises trig_hit_valid one cycle later and holds it until trig_hit_ack.
module el2_dec_trigger_ctl
  import el2_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         csr_wr_en,
  input  logic [1:0]                   csr_wr_addr,
  input  logic [31:0]                  csr_wr_data,
  input  logic [1:0]                   csr_rd_addr,
  output logic [31:0]                  csr_rd_data,
  input  logic                         dbg_mode,
  input  logic                         i0_valid,
  input  logic [NTRIG-1:0]             i0_match,
  input  logic                         lsu_valid,
  input  logic [NTRIG-1:0]             lsu_match,
  output el2_trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
  output logic                         trig_hit_valid,
  output logic [NTRIG-1:0]             trig_hit_vec,
  output logic                         trig_action,
  input  logic                         trig_hit_ack
);

  logic [1:0]             r_mtsel;
  logic [NTRIG-1:0]       r_dmode, r_hit, r_select, r_action, r_chain;
  logic [NTRIG-1:0]       r_match, r_m, r_exec, r_store, r_load;
  logic [NTRIG-1:0][31:0] r_tdata2;

  trig_state_e      r_state;
  logic             r_hit_valid;
  logic [NTRIG-1:0] r_hit_vec;
  logic             r_trig_action;

  logic             w_wr_prot;
  logic             w_wr_td1;
  logic             w_wr_td2;
  logic [NTRIG-1:0] w_q;
  logic [NTRIG-1:0] w_fired;
  logic [NTRIG-1:0] w_set_hit;
  logic [31:0]      w_mtdata1;

  // A debug-mode-owned trigger is locked against writes from normal mode.
  assign w_wr_prot = r_dmode[r_mtsel] & ~dbg_mode;
  assign w_wr_td1  = csr_wr_en & (csr_wr_addr == CSR_MTDATA1) & ~w_wr_prot;
  assign w_wr_td2  = csr_wr_en & (csr_wr_addr == CSR_MTDATA2) & ~w_wr_prot;

  always_comb begin
    w_q = '0;
    for (int i = 0; i < NTRIG; i++) begin
      w_q[i] = r_m[i] & ~dbg_mode &
               ((r_exec[i] & i0_valid & i0_match[i]) |
                ((r_load[i] | r_store[i]) & lsu_valid & lsu_match[i]));
    end
  end

  el2_trig_chain u_chain (
    .i_q      (w_q),
    .i_chain0 (r_chain[0]),
    .i_chain2 (r_chain[2]),
    .o_fired  (w_fired)
  );

  assign w_set_hit = (r_state == IDLE) ? w_fired : '0;

  // Hit-bit set is applied first so a same-cycle CSR write to the trigger overrides it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_mtsel  <= '0;
      r_dmode  <= '0;
      r_hit    <= '0;
      r_select <= '0;
      r_action <= '0;
      r_chain  <= '0;
      r_match  <= '0;
      r_m      <= '0;
      r_exec   <= '0;
      r_store  <= '0;
      r_load   <= '0;
      r_tdata2 <= '0;
    end else begin
      r_hit <= r_hit | w_set_hit;
      if (csr_wr_en && (csr_wr_addr == CSR_MTSEL)) begin
        r_mtsel <= csr_wr_data[1:0];
      end
      if (w_wr_td1) begin
        r_hit[r_mtsel]    <= csr_wr_data[B_HIT];
        r_select[r_mtsel] <= csr_wr_data[B_SELECT];
        r_action[r_mtsel] <= csr_wr_data[B_ACTION];
        r_match[r_mtsel]  <= csr_wr_data[B_MATCH];
        r_m[r_mtsel]      <= csr_wr_data[B_M];
        r_exec[r_mtsel]   <= csr_wr_data[B_EXEC];
        r_store[r_mtsel]  <= csr_wr_data[B_STORE];
        r_load[r_mtsel]   <= csr_wr_data[B_LOAD];
        if (dbg_mode) begin
          r_dmode[r_mtsel] <= csr_wr_data[B_DMODE];
        end
        if (!r_mtsel[0]) begin
          r_chain[r_mtsel] <= csr_wr_data[B_CHAIN];
        end
      end
      if (w_wr_td2) begin
        r_tdata2[r_mtsel] <= csr_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= IDLE;
      r_hit_valid   <= 1'b0;
      r_hit_vec     <= '0;
      r_trig_action <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_fired) begin
            r_state       <= PEND;
            r_hit_valid   <= 1'b1;
            r_hit_vec     <= w_fired;
            r_trig_action <= |(w_fired & r_action);
          end
        end
        PEND: begin
          if (trig_hit_ack) begin
            r_state       <= IDLE;
            r_hit_valid   <= 1'b0;
            r_hit_vec     <= '0;
            r_trig_action <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trig_hit_valid = r_hit_valid;
  assign trig_hit_vec   = r_hit_vec;
  assign trig_action    = r_trig_action;

  always_comb begin
    w_mtdata1           = '0;
    w_mtdata1[31:28]    = MTDATA1_TYPE;
    w_mtdata1[B_DMODE]  = r_dmode[r_mtsel];
    w_mtdata1[B_HIT]    = r_hit[r_mtsel];
    w_mtdata1[B_SELECT] = r_select[r_mtsel];
    w_mtdata1[B_ACTION] = r_action[r_mtsel];
    w_mtdata1[B_CHAIN]  = r_chain[r_mtsel];
    w_mtdata1[B_MATCH]  = r_match[r_mtsel];
    w_mtdata1[B_M]      = r_m[r_mtsel];
    w_mtdata1[B_EXEC]   = r_exec[r_mtsel];
    w_mtdata1[B_STORE]  = r_store[r_mtsel];
    w_mtdata1[B_LOAD]   = r_load[r_mtsel];
  end

  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_addr)
      CSR_MTSEL:   csr_rd_data = {30'b0, r_mtsel};
      CSR_MTDATA1: csr_rd_data = w_mtdata1;
      CSR_MTDATA2: csr_rd_data = r_tdata2[r_mtsel];
      default:     csr_rd_data = '0;
    endcase
  end

  always_comb begin
    trigger_pkt_any = '0;
    for (int i = 0; i < NTRIG; i++) begin
      trigger_pkt_any[i].select  = r_select[i];
      trigger_pkt_any[i].match   = r_match[i];
      trigger_pkt_any[i].store   = r_store[i];
      trigger_pkt_any[i].load    = r_load[i];
      trigger_pkt_any[i].execute = r_exec[i];
      trigger_pkt_any[i].m       = r_m[i];
      trigger_pkt_any[i].tdata2  = r_tdata2[i];
    end
  end

endmodule

// File: tb/tb_el2_dec_trigger_ctl.sv
// Directed bench for el2_dec_trigger_ctl with a word-level reference model checked every cycle.
module tb_el2_dec_trigger_ctl;
  import el2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        csr_wr_en = 1'b0;
  logic [1:0]  csr_wr_addr = '0;
  logic [31:0] csr_wr_data = '0;
  logic [1:0]  csr_rd_addr = '0;
  logic [31:0] csr_rd_data;
  logic        dbg_mode = 1'b0;
  logic        i0_valid = 1'b0;
  logic [3:0]  i0_match = '0;
  logic        lsu_valid = 1'b0;
  logic [3:0]  lsu_match = '0;
  el2_trigger_pkt_t [3:0] trigger_pkt_any;
  logic        trig_hit_valid;
  logic [3:0]  trig_hit_vec;
  logic        trig_action;
  logic        trig_hit_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  el2_dec_trigger_ctl dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .csr_wr_en       (csr_wr_en),
    .csr_wr_addr     (csr_wr_addr),
    .csr_wr_data     (csr_wr_data),
    .csr_rd_addr     (csr_rd_addr),
    .csr_rd_data     (csr_rd_data),
    .dbg_mode        (dbg_mode),
    .i0_valid        (i0_valid),
    .i0_match        (i0_match),
    .lsu_valid       (lsu_valid),
    .lsu_match       (lsu_match),
    .trigger_pkt_any (trigger_pkt_any),
    .trig_hit_valid  (trig_hit_valid),
    .trig_hit_vec    (trig_hit_vec),
    .trig_action     (trig_action),
    .trig_hit_ack    (trig_hit_ack)
  );

  always #5 clk = ~clk;

  // Reference model: each mtdata1 is one 32-bit word (type field added on read).
  localparam logic [31:0] TD1_WMASK = 32'h0018_18C7;
  logic [31:0] m_td1 [4];
  logic [31:0] m_td2 [4];
  logic [1:0]  m_sel;
  logic        m_pend;
  logic [3:0]  m_vec;
  logic        m_act;

  always @(posedge clk or negedge rst_l) begin : model
    logic [3:0]  q;
    logic [3:0]  f;
    logic [31:0] mask;
    logic        prot;
    if (!rst_l) begin
      for (int i = 0; i < 4; i++) begin
        m_td1[i] = '0;
        m_td2[i] = '0;
      end
      m_sel = '0; m_pend = 1'b0; m_vec = '0; m_act = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        q[i] = m_td1[i][6] && !dbg_mode &&
               ((m_td1[i][2] && i0_valid && i0_match[i]) ||
                ((m_td1[i][0] || m_td1[i][1]) && lsu_valid && lsu_match[i]));
      f = q;
      if (m_td1[0][11]) begin f[0] = q[0] & q[1]; f[1] = f[0]; end
      if (m_td1[2][11]) begin f[2] = q[2] & q[3]; f[3] = f[2]; end
      prot = m_td1[m_sel][27] && !dbg_mode;
      if (!m_pend && f != 4'd0) begin
        m_pend = 1'b1; m_vec = f; m_act = 1'b0;
        for (int i = 0; i < 4; i++)
          if (f[i]) begin
            m_td1[i][20] = 1'b1;
            if (m_td1[i][12]) m_act = 1'b1;
          end
      end else if (m_pend && trig_hit_ack) begin
        m_pend = 1'b0; m_vec = '0; m_act = 1'b0;
      end
      if (csr_wr_en) begin
        if (csr_wr_addr == 2'd1 && !prot) begin
          mask = TD1_WMASK;
          if (m_sel[0]) mask[11] = 1'b0;
          if (dbg_mode) mask[27] = 1'b1;
          m_td1[m_sel] = (m_td1[m_sel] & ~mask) | (csr_wr_data & mask);
        end else if (csr_wr_addr == 2'd2 && !prot) begin
          m_td2[m_sel] = csr_wr_data;
        end else if (csr_wr_addr == 2'd0) begin
          m_sel = csr_wr_data[1:0];
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd();
    case (csr_rd_addr)
      2'd0:    return {30'b0, m_sel};
      2'd1:    return m_td1[m_sel] | 32'h2000_0000;
      2'd2:    return m_td2[m_sel];
      default: return 32'h0;
    endcase
  endfunction

  function automatic el2_trigger_pkt_t exp_pkt(int i);
    el2_trigger_pkt_t p;
    p.select  = m_td1[i][19];
    p.match   = m_td1[i][7];
    p.store   = m_td1[i][1];
    p.load    = m_td1[i][0];
    p.execute = m_td1[i][2];
    p.m       = m_td1[i][6];
    p.tdata2  = m_td2[i];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit run = 1'b0;
  always @(negedge clk) begin
    if (run && rst_l) begin
      chk("model.valid", 64'(trig_hit_valid), 64'(m_pend));
      chk("model.vec", 64'(trig_hit_vec), 64'(m_vec));
      chk("model.action", 64'(trig_action), 64'(m_act));
      chk("model.rd_data", 64'(csr_rd_data), 64'(exp_rd()));
      for (int i = 0; i < 4; i++)
        chk($sformatf("model.pkt%0d", i), 64'(trigger_pkt_any[i]), 64'(exp_pkt(i)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    csr_wr_en = 1'b1; csr_wr_addr = a; csr_wr_data = d;
    cyc();
    csr_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    csr_rd_addr = a;
    #1;
    d = csr_rd_data;
  endtask

  task automatic ack();
    trig_hit_ack = 1'b1;
    cyc();
    trig_hit_ack = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    cyc(); cyc();
    chk("rst.valid", 64'(trig_hit_valid), 64'h0);
    chk("rst.vec", 64'(trig_hit_vec), 64'h0);
    chk("rst.pkt", 64'(|trigger_pkt_any), 64'h0);
    rd(2'd1, v); chk("rst.mtdata1", 64'(v), 64'h2000_0000);
    rst_l = 1'b1;
    run = 1'b1;
    cyc();

    // CSR map
    wr(2'd0, 32'd2); wr(2'd1, 32'h0000_0044); wr(2'd2, 32'h8000_0100);
    rd(2'd1, v); chk("csr.mtdata1", 64'(v), 64'h2000_0044);
    chk("csr.pkt2.exec", 64'(trigger_pkt_any[2].execute), 64'h1);
    chk("csr.pkt2.m", 64'(trigger_pkt_any[2].m), 64'h1);
    chk("csr.pkt2.tdata2", 64'(trigger_pkt_any[2].tdata2), 64'h8000_0100);
    wr(2'd0, 32'd5); rd(2'd0, v); chk("csr.mtsel_wrap", 64'(v), 64'h1);

    // Single execute hit on trigger 1, plus an ignored ack while idle
    ack();
    wr(2'd1, 32'h0000_0044);
    i0_valid = 1'b1; i0_match = 4'b0010;
    cyc();
    i0_valid = 1'b0; i0_match = '0;
    chk("exe.valid", 64'(trig_hit_valid), 64'h1);
    chk("exe.vec", 64'(trig_hit_vec), 64'h2);
    chk("exe.action", 64'(trig_action), 64'h0);
    rd(2'd1, v); chk("exe.hitbit", 64'(v), 64'h2010_0044);
    ack();
    chk("exe.ack", 64'(trig_hit_valid), 64'h0);

    // Chaining of pair 0-1
    wr(2'd0, 32'd0); wr(2'd1, 32'h0000_0844);
    i0_valid = 1'b1; i0_match = 4'b0001;
    cyc(); cyc();
    chk("chain.half", 64'(trig_hit_valid), 64'h0);
    i0_match = 4'b0011;
    cyc();
    i0_valid = 1'b0; i0_match = '0;
    chk("chain.vec", 64'(trig_hit_vec), 64'h3);
    ack();
    wr(2'd1, 32'h0000_0044);

    // Action bit drives enter-debug
    wr(2'd0, 32'd2); wr(2'd1, 32'h0000_1044);
    i0_valid = 1'b1; i0_match = 4'b0100;
    cyc();
    i0_valid = 1'b0; i0_match = '0;
    chk("act.vec", 64'(trig_hit_vec), 64'h4);
    chk("act.action", 64'(trig_action), 64'h1);
    ack();

    // Dmode protection
    dbg_mode = 1'b1;
    wr(2'd0, 32'd3); wr(2'd1, 32'h0800_0041); wr(2'd2, 32'h1234_5678);
    dbg_mode = 1'b0;
    wr(2'd2, 32'hFFFF_FFFF); wr(2'd1, 32'h0000_0000);
    rd(2'd2, v); chk("dmode.td2", 64'(v), 64'h1234_5678);
    rd(2'd1, v); chk("dmode.td1", 64'(v), 64'h2800_0041);
    dbg_mode = 1'b1;
    lsu_valid = 1'b1; lsu_match = 4'b1000; i0_valid = 1'b1; i0_match = 4'b1111;
    cyc(); cyc();
    chk("dmode.suppress", 64'(trig_hit_valid), 64'h0);
    lsu_valid = 1'b0; lsu_match = '0; i0_valid = 1'b0; i0_match = '0;
    dbg_mode = 1'b0;
    cyc();

    // Pending: new matches ignored, match in ack cycle dropped
    i0_valid = 1'b1; i0_match = 4'b0010;
    cyc();
    i0_valid = 1'b0; i0_match = '0;
    lsu_valid = 1'b1; lsu_match = 4'b1000;
    cyc(); cyc();
    chk("pend.vec", 64'(trig_hit_vec), 64'h2);
    rd(2'd1, v); chk("pend.t3hit", 64'(v), 64'h2800_0041);
    ack();
    chk("pend.ackdrop", 64'(trig_hit_valid), 64'h0);
    lsu_valid = 1'b0; lsu_match = '0;
    cyc();

    // Same-cycle mtdata1 write and hit-set: write wins
    wr(2'd0, 32'd1);
    csr_wr_en = 1'b1; csr_wr_addr = 2'd1; csr_wr_data = 32'h0000_0044;
    i0_valid = 1'b1; i0_match = 4'b0010;
    cyc();
    csr_wr_en = 1'b0; i0_valid = 1'b0; i0_match = '0;
    chk("race.valid", 64'(trig_hit_valid), 64'h1);
    rd(2'd1, v); chk("race.td1", 64'(v), 64'h2000_0044);

    // Asynchronous reset while pending
    wr(2'd0, 32'd2);
    @(posedge clk); #3;
    rst_l = 1'b0;
    #1;
    chk("arst.valid", 64'(trig_hit_valid), 64'h0);
    rd(2'd0, v); chk("arst.mtsel", 64'(v), 64'h0);
    cyc();
    rst_l = 1'b1;
    cyc();
    rd(2'd2, v); chk("arst.td2", 64'(v), 64'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
